// File: rtl/shift_reg_n.sv
// shift_reg_n: WIDTH-bit D flip-flop bank with synchronous reset, clock enable,
// parallel load, shift, rotate, arithmetic shift and clear, plus serial taps.
`default_nettype none

module shift_reg_n #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_l,
  output logic             sout_r
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH-1:0] asr_val;

  // A single bit has no neighbours: shifts take the serial input, rotates hold.
  generate
    if (WIDTH > 1) begin : g_wide
      assign shl_val = {q_r[WIDTH-2:0], sin_l};
      assign shr_val = {sin_r, q_r[WIDTH-1:1]};
      assign rol_val = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      assign ror_val = {q_r[0], q_r[WIDTH-1:1]};
      assign asr_val = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
    end else begin : g_single
      assign shl_val = sin_l;
      assign shr_val = sin_r;
      assign rol_val = q_r;
      assign ror_val = q_r;
      assign asr_val = q_r;
    end
  endgenerate

  always_comb begin
    q_next = q_r;
    case (mode)
      MODE_HOLD: q_next = q_r;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = shl_val;
      MODE_SHR:  q_next = shr_val;
      MODE_ROL:  q_next = rol_val;
      MODE_ROR:  q_next = ror_val;
      MODE_ASR:  q_next = asr_val;
      MODE_CLR:  q_next = {WIDTH{1'b0}};
      default:   q_next = q_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= RESET_VALUE;
    end else if (en) begin
      q_r <= q_next;
    end
  end

  assign q      = q_r;
  assign q_bar  = ~q_r;
  assign sout_l = q_r[WIDTH-1];
  assign sout_r = q_r[0];

endmodule

`default_nettype wire

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised WIDTH-bit register bank built from D flip-flops. It generalises the single-bit D flip-flop with synchronous reset, clock enable, parallel load, shift, rotate, arithmetic shift and clear modes, plus serial in/out on both ends. It is the storage and shift primitive for the counter, serial-converter and datapath blocks that follow in the same design set.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH ≥ 1.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q by reset; width WIDTH.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 holds state regardless of mode.
- mode  input  3  operation select, decoded below.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at bit 0 on shift-left.
- sin_r  input  1  serial input entering at bit WIDTH-1 on shift-right.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  bitwise complement of q.
- sout_l  output  1  equals q[WIDTH-1].
- sout_r  output  1  equals q[0].

## Operation
- One clock, one clock domain. Reset is synchronous and active-high, and all state is held in a single WIDTH-bit register.
- Priority at each rising edge:
  - reset = 1 gives q ← RESET_VALUE.
  - Otherwise en = 0 gives q ← q.
  - Otherwise the mode decode applies.
- Mode decode (q' is the next state):
  - 000 HOLD: q' = q.
  - 001 LOAD: q' = d.
  - 010 SHL: q' = {q[WIDTH-2:0], sin_l}.
  - 011 SHR: q' = {sin_r, q[WIDTH-1:1]}.
  - 100 ROL: q' = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q' = {q[0], q[WIDTH-1:1]}.
  - 110 ASR: q' = {q[WIDTH-1], q[WIDTH-1:1]}, sign bit replicated; sin_r is ignored.
  - 111 CLR: q' = all zeros. This is independent of RESET_VALUE.
- q_bar = ~q, combinational from the register with no separate state.
- sout_l and sout_r are combinational taps of q and are not registered separately.
- WIDTH = 1 boundary:
  - SHL gives q' = sin_l.
  - SHR gives q' = sin_r.
  - ROL, ROR and ASR give q' = q.
  - The implementation must not form zero-width or negative part-selects. Guard these cases with a generate on WIDTH.
- Inputs d, mode, sin_l and sin_r are sampled only at the rising edge. Changes between edges have no effect on q.
- No X propagation from unused inputs: d is ignored except in LOAD, and sin_l/sin_r are ignored except in SHL/SHR.

## Timing
- Latency is one cycle: the operation selected at edge N is visible on q after edge N.
- q_bar, sout_l and sout_r follow q within the same cycle, with combinational delay only.
- Reset values:
  - q = RESET_VALUE.
  - q_bar = ~RESET_VALUE.
  - sout_l = RESET_VALUE[WIDTH-1].
  - sout_r = RESET_VALUE[0].
- Reset asserted mid-sequence, for example during a run of shifts, overrides en and mode on that edge. Reset has no asynchronous effect: q changes only at the edge.
- Back-to-back operations are allowed every cycle with no bubbles. Each edge applies exactly one operation to the previous q.
- Simultaneous reset = 1 and en = 1 with LOAD results in q = RESET_VALUE.

## Test plan
Scenarios 1–5 use WIDTH = 8 and RESET_VALUE = 8'hA5; scenario 6 uses the widths stated in it.

1. Reset and load:
   - Hold reset high for 2 edges: q = A5, q_bar = 5A, sout_l = 1, sout_r = 1.
   - Then en = 1, LOAD d = 3C: q = 3C, q_bar = C3.
2. Shift with serial inputs:
   - From q = 81, SHL with sin_l = 0: q = 02, and sout_l drops from 1 to 0.
   - Then SHR with sin_r = 1 twice: q = 81, then C0.
3. Rotate wrap and arithmetic shift:
   - From q = 81, ROL gives 03 and ROR gives C0.
   - From q = 80, ASR three times: 80 → C0 → E0 → F0.
   - From q = 40, ASR gives 20 (sign bit 0 preserved).
4. Enable and clear:
   - en = 0 with mode = LOAD, d = FF: q stays unchanged for 3 edges.
   - en = 1, CLR: q = 00, q_bar = FF. This differs from the reset value A5.
5. Reset mid-operation:
   - Load 0F, then issue SHL on edges 1 and 2, and assert reset with SHL on edge 3.
   - Required q: 1E, 3C, then A5.
   - Verify that q does not change between edges when reset is raised off-edge.
6. WIDTH = 1 instance (RESET_VALUE = 1'b0):
   - SHL with sin_l = 1 gives q = 1.
   - ROL and ASR hold q = 1.
   - SHR with sin_r = 0 gives q = 0.
   - Replicate the single-bit D flip-flop pattern: LOAD every cycle with d toggling mid-period; q tracks d at each edge and q_bar = ~q.
